// File: rtl/guess_scorer_pkg.sv
// rtl/guess_scorer_pkg.sv - shared game constants and scorer FSM state type
package guess_scorer_pkg;
  localparam int GAME_COLOR_W     = 5;
  localparam int GAME_POS_W       = 5;
  localparam int max_pins_count   = 20;
  localparam int max_guesses      = 99;
  localparam int ram_hints_offset = max_pins_count * max_guesses;
  localparam int RAM_ADDR_W       = 12;

  typedef enum logic [2:0] {
    IDLE,
    GREEN,
    YELLOW,
    UPLOAD,
    HINTS,
    DONE
  } state_e;
endpackage

// File: rtl/guess_scorer_pin_match_mask.sv
// rtl/guess_scorer_pin_match_mask.sv - first unmasked pin at or after start_idx whose color matches
module pin_match_mask
  import guess_scorer_pkg::*;
#(
  parameter int MAX_PINS = max_pins_count,
  parameter int COLOR_W  = GAME_COLOR_W,
  parameter int POS_W    = GAME_POS_W
) (
  input  logic [MAX_PINS*COLOR_W-1:0] colors,
  input  logic [MAX_PINS-1:0]         mask,
  input  logic [COLOR_W-1:0]          color,
  input  logic [POS_W-1:0]            start_idx,
  input  logic [POS_W-1:0]            count,
  output logic                        found,
  output logic [POS_W-1:0]            idx
);
  always_comb begin
    found = 1'b0;
    idx   = count;
    // Descending scan so the lowest qualifying index wins.
    for (int k = MAX_PINS - 1; k >= 0; k--) begin
      if (POS_W'(k) >= start_idx && POS_W'(k) < count && !mask[k] &&
          colors[k*COLOR_W +: COLOR_W] == color) begin
        found = 1'b1;
        idx   = POS_W'(k);
      end
    end
  end
endmodule

// File: rtl/guess_scorer.sv
// rtl/guess_scorer.sv - scores a guess against the secret (green/yellow) and uploads pins and hints to RAM
module guess_scorer
  import guess_scorer_pkg::*;
#(
  parameter int MAX_PINS   = max_pins_count,
  parameter int COLOR_W    = GAME_COLOR_W,
  parameter int POS_W      = GAME_POS_W,
  parameter int HINTS_BASE = ram_hints_offset
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [POS_W-1:0]            pins_count,
  input  logic [7:0]                  guessed_count,
  input  logic [MAX_PINS*COLOR_W-1:0] guess,
  input  logic [MAX_PINS*COLOR_W-1:0] secret,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [POS_W-1:0]            green,
  output logic [POS_W-1:0]            yellow,
  output logic                        ram_we,
  output logic [RAM_ADDR_W-1:0]       ram_addr,
  output logic [2*POS_W-1:0]          ram_wdata,
  input  logic                        ram_ready
);
  localparam int VEC_W = MAX_PINS * COLOR_W;
  localparam logic [POS_W-1:0] ONE = POS_W'(1);

  state_e               state_q, state_d;
  logic [POS_W-1:0]     n_q, n_d, i_q, i_d, j_q, j_d;
  logic [POS_W-1:0]     green_q, green_d, yellow_q, yellow_d;
  logic [7:0]           gc_q, gc_d;
  logic [VEC_W-1:0]     guess_q, guess_d, secret_q, secret_d;
  logic [MAX_PINS-1:0]  gmask_q, gmask_d, smask_q, smask_d;
  logic                 err_q, err_d;
  logic [COLOR_W-1:0]   guess_pin, secret_pin;
  logic                 match_found, adv_i;
  logic [POS_W-1:0]     match_idx, next_i;

  // Lowest unmasked guess index in [from, n); returns n when none remain.
  function automatic logic [POS_W-1:0] first_free(input logic [MAX_PINS-1:0] m,
                                                  input logic [POS_W-1:0] from,
                                                  input logic [POS_W-1:0] n);
    logic [POS_W-1:0] r;
    r = n;
    for (int k = MAX_PINS - 1; k >= 0; k--) begin
      if (POS_W'(k) >= from && POS_W'(k) < n && !m[k]) r = POS_W'(k);
    end
    return r;
  endfunction

  assign guess_pin  = guess_q[i_q*COLOR_W +: COLOR_W];
  assign secret_pin = secret_q[i_q*COLOR_W +: COLOR_W];

  pin_match_mask #(.MAX_PINS(MAX_PINS), .COLOR_W(COLOR_W), .POS_W(POS_W)) u_match (
    .colors    (secret_q),
    .mask      (smask_q),
    .color     (guess_pin),
    .start_idx (j_q),
    .count     (n_q),
    .found     (match_found),
    .idx       (match_idx)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    i_d       = i_q;
    j_d       = j_q;
    green_d   = green_q;
    yellow_d  = yellow_q;
    gc_d      = gc_q;
    guess_d   = guess_q;
    secret_d  = secret_q;
    gmask_d   = gmask_q;
    smask_d   = smask_q;
    err_d     = 1'b0;
    adv_i     = 1'b0;
    next_i    = '0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (guessed_count >= 8'(max_guesses)) begin
            err_d = 1'b1;
          end else begin
            n_d      = (pins_count > POS_W'(MAX_PINS)) ? POS_W'(MAX_PINS) : pins_count;
            gc_d     = guessed_count;
            guess_d  = guess;
            secret_d = secret;
            green_d  = '0;
            yellow_d = '0;
            gmask_d  = '0;
            smask_d  = '0;
            i_d      = '0;
            j_d      = '0;
            state_d  = GREEN;
          end
        end
      end
      GREEN: begin
        if (n_q == '0) begin
          state_d = HINTS;
        end else begin
          if (guess_pin == secret_pin) begin
            green_d        = green_q + ONE;
            gmask_d[i_q]   = 1'b1;
            smask_d[i_q]   = 1'b1;
          end
          if (i_q == n_q - ONE) begin
            // Already-green guess pins are skipped here so YELLOW never spends a cycle on them.
            next_i = first_free(gmask_d, '0, n_q);
            j_d    = '0;
            if (next_i == n_q) begin
              state_d = UPLOAD;
              i_d     = '0;
            end else begin
              state_d = YELLOW;
              i_d     = next_i;
            end
          end else begin
            i_d = i_q + ONE;
          end
        end
      end
      YELLOW: begin
        if (match_found && match_idx == j_q) begin
          yellow_d     = yellow_q + ONE;
          smask_d[j_q] = 1'b1;
          adv_i        = 1'b1;
        end else if (j_q == n_q - ONE) begin
          adv_i = 1'b1;
        end else begin
          j_d = j_q + ONE;
        end
        if (adv_i) begin
          next_i = first_free(gmask_q, i_q + ONE, n_q);
          j_d    = '0;
          if (next_i == n_q) begin
            state_d = UPLOAD;
            i_d     = '0;
          end else begin
            i_d = next_i;
          end
        end
      end
      UPLOAD: begin
        ram_we    = 1'b1;
        ram_addr  = RAM_ADDR_W'(gc_q) * RAM_ADDR_W'(MAX_PINS) + RAM_ADDR_W'(i_q);
        ram_wdata = (2*POS_W)'(guess_pin);
        if (ram_ready) begin
          if (i_q == n_q - ONE) state_d = HINTS;
          else                  i_d     = i_q + ONE;
        end
      end
      HINTS: begin
        ram_we    = 1'b1;
        ram_addr  = RAM_ADDR_W'(HINTS_BASE) + RAM_ADDR_W'(gc_q);
        ram_wdata = {green_q, yellow_q};
        if (ram_ready) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      gc_q     <= '0;
      guess_q  <= '0;
      secret_q <= '0;
      gmask_q  <= '0;
      smask_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      i_q      <= i_d;
      j_q      <= j_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      gc_q     <= gc_d;
      guess_q  <= guess_d;
      secret_q <= secret_d;
      gmask_q  <= gmask_d;
      smask_q  <= smask_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign err    = err_q;
  assign green  = green_q;
  assign yellow = yellow_q;
endmodule

// File: tb/tb_guess_scorer.sv
// tb/tb_guess_scorer.sv - scoreboard bench for guess_scorer
module tb_guess_scorer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   pins_count = '0;
  logic [7:0]   guessed_count = '0;
  logic [99:0]  guess = '0;
  logic [99:0]  secret = '0;
  logic         busy, done, err;
  logic [4:0]   green, yellow;
  logic         ram_we;
  logic [11:0]  ram_addr;
  logic [9:0]   ram_wdata;
  logic         ram_ready = 1'b1;
  logic         toggle = 1'b0;

  typedef struct {
    int kind;
    int addr;
    int data;
    int grn;
    int yel;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;

  guess_scorer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .pins_count    (pins_count),
    .guessed_count (guessed_count),
    .guess         (guess),
    .secret        (secret),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .green         (green),
    .yellow        (yellow),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata),
    .ram_ready     (ram_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    ram_ready = toggle ? ~ram_ready : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic take(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      check("unexpected_event_kind", kind, -1);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      if (e.kind == 0) begin
        check("wr_addr", ram_addr, e.addr);
        check("wr_data", ram_wdata, e.data);
      end else if (e.kind == 1) begin
        check("done_green", green, e.grn);
        check("done_yellow", yellow, e.yel);
        if (e.lat > 0) check("latency", cyc - start_cyc, e.lat);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we && ram_ready) take(0);
      if (done) take(1);
      if (err) take(2);
    end
  end

  function automatic logic [99:0] pk4(input int a, input int b, input int c, input int d);
    logic [99:0] v;
    v = '0;
    v[0+:5]  = 5'(a);
    v[5+:5]  = 5'(b);
    v[10+:5] = 5'(c);
    v[15+:5] = 5'(d);
    return v;
  endfunction

  function automatic logic [99:0] ramp();
    logic [99:0] v;
    for (int k = 0; k < 20; k++) v[k*5+:5] = 5'(k);
    return v;
  endfunction

  task automatic pulse_start(input int pins, input int gc, input logic [99:0] g, input logic [99:0] s);
    pins_count    = 5'(pins);
    guessed_count = 8'(gc);
    guess         = g;
    secret        = s;
    start         = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue_case(input int pins, input int gc, input logic [99:0] g, input logic [99:0] s,
                            input int grn, input int yel, input int lat);
    int eff;
    eff = (pins > 20) ? 20 : pins;
    for (int k = 0; k < eff; k++) sb.push_back('{0, gc*20 + k, int'(g[k*5+:5]), 0, 0, 0});
    sb.push_back('{0, 1980 + gc, grn*32 + yel, 0, 0, 0});
    sb.push_back('{1, 0, 0, grn, yel, lat});
    start_cyc = cyc;
    pulse_start(pins, gc, g, s);
  endtask

  task automatic drain();
    for (int t = 0; t < 3000 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check("drain_queue_empty", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_green", green, 0);
    check("rst_yellow", yellow, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue_case(4, 3, pk4(1, 2, 3, 4), pk4(1, 2, 3, 4), 4, 0, 10);
    drain();

    issue_case(4, 0, pk4(4, 3, 2, 1), pk4(1, 2, 3, 4), 0, 4, 20);
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid_op", busy, 1);
    pulse_start(4, 50, pk4(7, 7, 7, 7), pk4(7, 7, 7, 7));
    drain();

    issue_case(4, 5, pk4(1, 2, 1, 1), pk4(1, 1, 2, 2), 1, 2, 19);
    drain();

    sb.push_back('{2, 0, 0, 0, 0, 0});
    pulse_start(4, 99, pk4(1, 1, 1, 1), pk4(1, 1, 1, 1));
    repeat (3) @(posedge clk);
    #1;
    check("err_stays_idle", busy, 0);
    check("err_green_kept", green, 1);
    check("err_yellow_kept", yellow, 2);
    drain();

    toggle = 1'b1;
    issue_case(20, 7, ramp(), ramp(), 20, 0, 0);
    drain();
    toggle = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    issue_case(30, 98, '0, '0, 20, 0, 42);
    drain();

    issue_case(0, 10, pk4(3, 3, 3, 3), pk4(3, 3, 3, 3), 0, 0, 0);
    drain();

    sb.push_back('{0, 400, 1, 0, 0, 0});
    sb.push_back('{0, 401, 2, 0, 0, 0});
    sb.push_back('{0, 402, 3, 0, 0, 0});
    pulse_start(4, 20, pk4(1, 2, 3, 4), pk4(1, 2, 3, 4));
    for (int t = 0; t < 200 && !(ram_we && ram_addr == 12'd403); t++) begin
      @(posedge clk);
      #1;
    end
    check("reach_upload_i3", ram_addr, 403);
    rst_n = 1'b0;
    #1;
    check("abort_ram_we", ram_we, 0);
    check("abort_busy", busy, 0);
    check("abort_green", green, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("abort_idle", busy, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/guess_scorer.md
GUESS_SCORER -- requirements
Module: guess_scorer

Interface
REQ-001 SHALL have parameter MAX_PINS, default 20, meaning the number of pin slots in the guess and secret vectors.
REQ-002 SHALL have parameter COLOR_W, default 5, meaning the width of one pin color.
REQ-003 SHALL have parameter POS_W, default 5, meaning the width of pin index and count values.
REQ-004 SHALL have parameter HINTS_BASE, default 1980, meaning the RAM address of hint row 0 (MAX_PINS*99).
REQ-005 SHALL have ports: clk in 1, one clock; rst_n in 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports: start in 1, request pulse; pins_count in POS_W, active pins; guessed_count in 8, row index of this guess.
REQ-007 SHALL have ports: guess in MAX_PINS*COLOR_W, flattened guess with pin i at bits [i*COLOR_W +: COLOR_W]; secret in MAX_PINS*COLOR_W, same layout.
REQ-008 SHALL have ports: busy out 1; done out 1, one-cycle completion pulse; err out 1, one-cycle rejection pulse.
REQ-009 SHALL have ports: green out POS_W; yellow out POS_W.
REQ-010 SHALL have ports: ram_we out 1; ram_addr out 12; ram_wdata out 2*POS_W; ram_ready in 1, write accepted this cycle.

Function
REQ-011 SHALL implement the FSM states IDLE, GREEN, YELLOW, UPLOAD, HINTS, DONE.
REQ-012 SHALL accept start only in IDLE, latching pins_count, guessed_count, guess and secret, and ignore start in all other states.
REQ-013 SHALL clamp a latched pins_count >MAX_PINS to MAX_PINS.
REQ-014 SHALL, on start with guessed_count >=99, pulse err for 1 cycle, perform no write and remain in IDLE.
REQ-015 SHALL clear green, yellow, the analyzed_guess mask and the analyzed_secret mask on accepted start.
REQ-016 SHALL, in GREEN, examine one index i per cycle for i = 0..N-1; on guess[i]==secret[i], increment green and set both mask bits i.
REQ-017 SHALL, in YELLOW, examine one pair (i,j) per cycle, skipping masked i in 0 cycles.
REQ-018 SHALL, in YELLOW, on an unmasked secret[j]==guess[i], increment yellow, set analyzed_secret[j] and advance i, else advance j.
REQ-019 SHALL, in YELLOW, when j reaches N, advance i and reset j to 0; YELLOW ends when i reaches N.
REQ-020 SHALL, in UPLOAD, assert ram_we with ram_addr=guessed_count*MAX_PINS+i and ram_wdata={0,guess[i]}, advancing i only on a cycle with ram_ready=1.
REQ-021 SHALL, in HINTS, assert ram_we with ram_addr=HINTS_BASE+guessed_count and ram_wdata={green,yellow}, holding until ram_ready=1.
REQ-022 SHALL, in DONE, pulse done for 1 cycle and return to IDLE.
REQ-023 SHALL hold green and yellow stable from DONE until the next accepted start.
REQ-024 SHALL, for N=0, go from GREEN straight to HINTS, writing {0,0}.
REQ-025 SHALL achieve a latency from start to done of N + yellow-pair cycles + N + 2 cycles when ram_ready is held at 1.
REQ-026 SHALL assert busy in every state except IDLE.
REQ-027 SHALL hold ram_we=0 outside UPLOAD and HINTS.
REQ-028 SHALL compute all address arithmetic in 12 bits without overflow, the maximum address being 2078.

Reset
REQ-029 SHALL, on rst_n low, immediately enter IDLE and reset busy, done, err, ram_we, green, yellow, ram_addr, ram_wdata and both masks to 0.
REQ-030 SHALL, on reset mid-operation, abort with no further writes, and SHALL NOT replay the partially completed upload after reset.

Structure
REQ-031 SHALL place the COLOR_W/POS_W widths, max_pins_count, max_guesses and ram_hints_offset constants in the shared game package, and guess_scorer SHALL take its defaults from them.
REQ-032 SHALL contain one sub-module, pin_match_mask, the combinational "first unmasked j with secret[j]==color" finder.

Verification
REQ-033 SHALL be verified by: N=4, secret 1,2,3,4, guess 1,2,3,4 -> green=4, yellow=0, 4 pin writes then hints {4,0} at 1980+gc.
REQ-034 SHALL be verified by: N=4, secret 1,2,3,4, guess 4,3,2,1 -> green=0, yellow=4.
REQ-035 SHALL be verified by: N=4, secret 1,1,2,2, guess 1,2,1,1 -> green=1, yellow=2, with duplicates not double-counted.
REQ-036 SHALL be verified by: gc=7, N=20, ram_ready toggling 1/0 -> addresses 140..159 each written once in order, then 1987, no skipped or duplicated address.
REQ-037 SHALL be verified by: start with gc=99 -> err pulse, no ram_we; and start while busy -> ignored, result unchanged.
REQ-038 SHALL be verified by: rst_n low during UPLOAD at i=3 -> ram_we low immediately, busy=0, no hints write.
